// File: rtl/frame_pixel_streamer.sv
// Frame RAM reader that streams one IMG_W x IMG_H frame row-major with valid/ready and ROW_GAP idle cycles between rows.
// Optional STREAM_CHECKSUM_EN adds checksum_o, the mod-2^16 sum of the pixels accepted in the current frame.
module frame_pixel_streamer #(
  parameter int DATA_W  = 8,
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 48,
  parameter int ADDR_W  = 16,
  parameter int ROW_GAP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              ready_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] pixel_o,
  output logic              valid_o,
  output logic              sol_o,
  output logic              eol_o,
  output logic              busy_o,
  output logic              frame_done_o
`ifdef STREAM_CHECKSUM_EN
  ,
  output logic [15:0]       checksum_o
`endif
);

  // state  | meaning
  // IDLE   | waiting for start_i
  // STREAM | fetching and emitting the current row
  // GAP    | idle cycles between rows, no reads
  // LAST   | all reads issued, draining the final pixels
  // DONE   | one-cycle frame_done_o pulse
  typedef enum logic [2:0] {S_IDLE, S_STREAM, S_GAP, S_LAST, S_DONE} state_t;

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int GW = (ROW_GAP > 2) ? $clog2(ROW_GAP) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  // The first read of the next row covers the final idle cycle, so GAP lasts ROW_GAP-1 cycles.
  localparam logic [GW-1:0] GAP_LOAD = GW'((ROW_GAP >= 2) ? ROW_GAP - 2 : 0);

  state_t            state_q;
  logic [CW-1:0]     fcol_q, ecol_q;
  logic [RW-1:0]     frow_q, erow_q;
  logic              fhold_q;
  logic [GW-1:0]     gap_cnt_q;
  logic              rd_q;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic              busy_q, done_q;

  logic              credit_ok, rd, valid, hs, eol_hs;
  logic              f_last_col, f_last_row, e_last_col, e_last_row;
  logic [DATA_W-1:0] pix;

  always_comb begin
    f_last_col = (fcol_q == COL_LAST);
    f_last_row = (frow_q == ROW_LAST);
    e_last_col = (ecol_q == COL_LAST);
    e_last_row = (erow_q == ROW_LAST);
    credit_ok  = (cnt_q == 2'd0) || ((cnt_q == 2'd1) && !rd_q);
    rd         = (state_q == S_STREAM) && !fhold_q && credit_ok;
    valid      = (cnt_q != 2'd0) || rd_q;
    // Empty buffer: the arriving RAM word is presented directly so the first pixel is not delayed.
    if (cnt_q != 2'd0)
      pix = buf0_q;
    else if (rd_q)
      pix = mem_data_i;
    else
      pix = '0;
    hs     = valid && ready_i;
    eol_hs = hs && e_last_col;
  end

  always_comb begin
    cnt_d  = cnt_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    case (cnt_q)
      2'd0: begin
        if (rd_q && !ready_i) begin
          buf0_d = mem_data_i;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (hs) begin
          if (rd_q)
            buf0_d = mem_data_i;
          else
            cnt_d = 2'd0;
        end else if (rd_q) begin
          buf1_d = mem_data_i;
          cnt_d  = 2'd2;
        end
      end
      default: begin
        if (hs) begin
          buf0_d = buf1_q;
          cnt_d  = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      fcol_q    <= '0;
      frow_q    <= '0;
      fhold_q   <= 1'b0;
      ecol_q    <= '0;
      erow_q    <= '0;
      gap_cnt_q <= '0;
      rd_q      <= 1'b0;
      cnt_q     <= '0;
      buf0_q    <= '0;
      buf1_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rd_q   <= rd;
      cnt_q  <= cnt_d;
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
      done_q <= 1'b0;

      if (hs) begin
        if (e_last_col) begin
          ecol_q <= '0;
          erow_q <= e_last_row ? '0 : erow_q + RW'(1);
        end else begin
          ecol_q <= ecol_q + CW'(1);
        end
      end

      // Without a gap the fetch runs straight into the next row; otherwise it parks at the row end.
      if (rd) begin
        if (!f_last_col) begin
          fcol_q <= fcol_q + CW'(1);
        end else if (ROW_GAP == 0 && !f_last_row) begin
          fcol_q <= '0;
          frow_q <= frow_q + RW'(1);
        end else begin
          fhold_q <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_STREAM;
            busy_q  <= 1'b1;
            fcol_q  <= '0;
            frow_q  <= '0;
            fhold_q <= 1'b0;
            ecol_q  <= '0;
            erow_q  <= '0;
          end
        end
        S_STREAM: begin
          if (rd && f_last_col && f_last_row) begin
            state_q <= S_LAST;
          end else if (eol_hs && !e_last_row && ROW_GAP > 0) begin
            fcol_q  <= '0;
            frow_q  <= frow_q + RW'(1);
            fhold_q <= 1'b0;
            if (ROW_GAP >= 2) begin
              state_q   <= S_GAP;
              gap_cnt_q <= GAP_LOAD;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt_q == '0)
            state_q <= S_STREAM;
          else
            gap_cnt_q <= gap_cnt_q - GW'(1);
        end
        S_LAST: begin
          if (hs && e_last_col && e_last_row) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef STREAM_CHECKSUM_EN
  logic [15:0] checksum_q;

  always_ff @(posedge clk) begin
    if (rst)
      checksum_q <= '0;
    else if (state_q == S_IDLE && start_i)
      checksum_q <= '0;
    else if (hs)
      checksum_q <= checksum_q + 16'(pix);
  end

  assign checksum_o = checksum_q;
`endif

  assign mem_rd_o     = rd;
  assign mem_addr_o   = rd ? (ADDR_W'(frow_q) * ADDR_W'(IMG_W) + ADDR_W'(fcol_q)) : '0;
  assign pixel_o      = pix;
  assign valid_o      = valid;
  assign sol_o        = valid && (ecol_q == '0);
  assign eol_o        = valid && e_last_col;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Bench for frame_pixel_streamer at IMG_W=4, IMG_H=3, ROW_GAP=2 against a row-major frame model and a behavioural RAM.
module tb_frame_pixel_streamer;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 16;
  localparam int G  = 2;
  localparam int N  = W * H;
  localparam int DK = 2 + (H - 1) * (W + G) + W;  // cycle offset of frame_done_o after start acceptance

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0;
  logic ready_i = 1'b1;
  logic mem_rd_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_i;
  logic [DW-1:0] pixel_o;
  logic valid_o, sol_o, eol_o, busy_o, frame_done_o;
`ifdef STREAM_CHECKSUM_EN
  logic [15:0] checksum_o;
`endif

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] ram [0:15];

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (mem_rd_o) mem_data_i <= ram[mem_addr_o[3:0]];
  end

  frame_pixel_streamer #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .ROW_GAP(G)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .ready_i(ready_i),
    .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .pixel_o(pixel_o), .valid_o(valid_o), .sol_o(sol_o), .eol_o(eol_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o)
`ifdef STREAM_CHECKSUM_EN
    , .checksum_o(checksum_o)
`endif
  );

  task automatic fill_ram(input bit rnd);
    for (int a = 0; a < 16; a++) ram[a] = rnd ? 8'($urandom) : 8'(a + 1);
  endtask

  // Returns at the negedge of the first cycle after start acceptance (offset k=1).
  task automatic kick();
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; ready_i = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (valid_o !== 1'b0 || mem_rd_o !== 1'b0 || busy_o !== 1'b0 || frame_done_o !== 1'b0 ||
        pixel_o !== '0 || sol_o !== 1'b0 || eol_o !== 1'b0 || mem_addr_o !== '0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b rd=%b busy=%b done=%b pix=%0d sol=%b eol=%b addr=%0d, required all 0",
               valid_o, mem_rd_o, busy_o, frame_done_o, pixel_o, sol_o, eol_o, mem_addr_o);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (busy_o !== 1'b0 || mem_rd_o !== 1'b0 || valid_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b rd=%b valid=%b, required 0 0 0 without start", busy_o, mem_rd_o, valid_o);
    end
  endtask

  task automatic test_basic_frame();
    int p, r, c;
    bit ev;
    fill_ram(1'b0); ready_i = 1'b1;
    kick();
    for (int k = 1; k <= DK + 4; k++) begin
      if (k > 1) @(negedge clk);
      ev = 1'b0; r = 0; c = 0;
      if (k >= 2) begin
        p = k - 2; r = p / (W + G); c = p % (W + G);
        ev = (c < W) && (r < H);
      end
      if (k == 1) begin
        tests++;
        if (mem_rd_o !== 1'b1 || valid_o !== 1'b0) begin
          fails++;
          $display("FAIL basic_latency: rd=%b valid=%b at k=1, required rd=1 valid=0", mem_rd_o, valid_o);
        end
      end
      tests++;
      if (valid_o !== ev) begin
        fails++;
        $display("FAIL basic_valid k=%0d: got %b, required %b", k, valid_o, ev);
      end
      if (ev) begin
        tests++;
        if (pixel_o !== ram[r * W + c] || sol_o !== (c == 0) || eol_o !== (c == W - 1)) begin
          fails++;
          $display("FAIL basic_pixel k=%0d: got pix=%0d sol=%b eol=%b, required pix=%0d sol=%b eol=%b",
                   k, pixel_o, sol_o, eol_o, ram[r * W + c], (c == 0), (c == W - 1));
        end
      end
      tests++;
      if (frame_done_o !== (k == DK) || busy_o !== (k < DK)) begin
        fails++;
        $display("FAIL basic_done_busy k=%0d: done=%b busy=%b, required done=%b busy=%b",
                 k, frame_done_o, busy_o, (k == DK), (k < DK));
      end
`ifdef STREAM_CHECKSUM_EN
      if (k == DK) begin
        tests++;
        if (checksum_o !== 16'd78) begin
          fails++;
          $display("FAIL basic_checksum: got %0d, required 78", checksum_o);
        end
      end
`endif
    end
  endtask

  // Start pulses while busy and on the done cycle, with ready_i low through every gap.
  task automatic test_ignored_inputs();
    int p, r, c;
    bit ev, in_gap;
    fill_ram(1'b0); ready_i = 1'b1;
    kick();
    for (int k = 1; k <= DK + 8; k++) begin
      if (k > 1) @(negedge clk);
      ev = 1'b0; in_gap = 1'b0; r = 0; c = 0;
      if (k >= 2) begin
        p = k - 2; r = p / (W + G); c = p % (W + G);
        ev = (c < W) && (r < H);
        in_gap = (c >= W) && (r < H - 1);
      end
      tests++;
      if (valid_o !== ev || busy_o !== (k < DK) || frame_done_o !== (k == DK) ||
          (ev && pixel_o !== ram[r * W + c])) begin
        fails++;
        $display("FAIL ignored_k%0d: valid=%b busy=%b done=%b pix=%0d, required valid=%b busy=%b done=%b pix=%0d",
                 k, valid_o, busy_o, frame_done_o, pixel_o, ev, (k < DK), (k == DK), ev ? ram[r * W + c] : 8'd0);
      end
      start_i = (k == 8) || (k == DK);
      ready_i = !in_gap;
    end
    start_i = 1'b0; ready_i = 1'b1;
  endtask

  task automatic test_backpressure();
    int stall = 0, rd_issued = 0, acc = 0;
    bit hold_prev = 1'b0, done = 1'b0;
    logic [DW-1:0] held;
    logic [DW-1:0] got [$];
    fill_ram(1'b0); ready_i = 1'b1;
    kick();
    for (int k = 1; k <= 60 && !done; k++) begin
      if (k > 1) @(negedge clk);
      tests++;
      if (rd_issued - acc > 2) begin
        fails++;
        $display("FAIL bp_outstanding k=%0d: %0d held+in flight, required <= 2", k, rd_issued - acc);
      end
      if (hold_prev) begin
        tests++;
        if (valid_o !== 1'b1 || pixel_o !== held) begin
          fails++;
          $display("FAIL bp_hold k=%0d: valid=%b pix=%0d, required valid=1 pix=%0d", k, valid_o, pixel_o, held);
        end
      end
      if (mem_rd_o) rd_issued++;
      ready_i = 1'b1;
      if (valid_o && pixel_o == 8'd6 && stall < 3) begin
        ready_i = 1'b0;
        stall++;
      end
      hold_prev = valid_o && !ready_i;
      held = pixel_o;
      if (valid_o && ready_i) begin
        got.push_back(pixel_o);
        acc++;
      end
      if (frame_done_o) done = 1'b1;
    end
    ready_i = 1'b1;
    tests++;
    if (!done || stall != 3 || got.size() != N) begin
      fails++;
      $display("FAIL bp_frame: done=%b stalls=%0d pixels=%0d, required done=1 stalls=3 pixels=%0d", done, stall, got.size(), N);
    end
    for (int i = 0; i < got.size() && i < N; i++) begin
      tests++;
      if (got[i] !== 8'(i + 1)) begin
        fails++;
        $display("FAIL bp_order[%0d]: got %0d, required %0d", i, got[i], i + 1);
      end
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 6; f++) begin
      int i = 0;
      int sum = 0;
      bit done = 1'b0, hold_prev = 1'b0;
      logic [DW-1:0] held_pix;
      logic held_sol, held_eol;
      fill_ram(f == 5);
      kick();
      for (int k = 1; k <= 200 && !done; k++) begin
        if (k > 1) @(negedge clk);
        if (hold_prev) begin
          tests++;
          if (valid_o !== 1'b1 || pixel_o !== held_pix || sol_o !== held_sol || eol_o !== held_eol) begin
            fails++;
            $display("FAIL rnd_hold f=%0d k=%0d: valid=%b pix=%0d, required held pix=%0d", f, k, valid_o, pixel_o, held_pix);
          end
        end
        if (valid_o) begin
          tests++;
          if (i >= N || pixel_o !== ram[i] || sol_o !== (i % W == 0) || eol_o !== (i % W == W - 1)) begin
            fails++;
            $display("FAIL rnd_pixel f=%0d idx=%0d: pix=%0d sol=%b eol=%b, required pix=%0d sol=%b eol=%b",
                     f, i, pixel_o, sol_o, eol_o, ram[i % 16], (i % W == 0), (i % W == W - 1));
          end
        end
        ready_i = 1'($urandom_range(0, 1));
        hold_prev = valid_o && !ready_i;
        held_pix = pixel_o; held_sol = sol_o; held_eol = eol_o;
        if (valid_o && ready_i) begin
          sum += int'(pixel_o);
          i++;
        end
        if (frame_done_o) begin
          done = 1'b1;
          tests++;
          if (i != N) begin
            fails++;
            $display("FAIL rnd_count f=%0d: %0d pixels at frame_done_o, required %0d", f, i, N);
          end
`ifdef STREAM_CHECKSUM_EN
          tests++;
          if (checksum_o !== 16'(sum)) begin
            fails++;
            $display("FAIL rnd_checksum f=%0d: got %0d, required %0d", f, checksum_o, 16'(sum));
          end
`endif
        end
      end
      ready_i = 1'b1;
      tests++;
      if (!done) begin
        fails++;
        $display("FAIL rnd_timeout f=%0d: frame_done_o=0 after 200 cycles, required 1", f);
      end
      repeat (3) begin
        @(negedge clk);
        tests++;
        if (frame_done_o !== 1'b0 || valid_o !== 1'b0) begin
          fails++;
          $display("FAIL rnd_after f=%0d: done=%b valid=%b, required 0 0", f, frame_done_o, valid_o);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    bit hit = 1'b0, done = 1'b0;
    int got = 0;
    fill_ram(1'b0); ready_i = 1'b1;
    kick();
    for (int k = 1; k <= 40 && !hit; k++) begin
      if (k > 1) @(negedge clk);
      if (valid_o && pixel_o == 8'd7) begin
        hit = 1'b1;
        rst = 1'b1;
      end
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL mrst_reach: pixel 7 not seen in 40 cycles, required seen");
    end
    @(negedge clk);
    tests++;
    if (valid_o !== 1'b0 || mem_rd_o !== 1'b0 || busy_o !== 1'b0 || frame_done_o !== 1'b0 ||
        pixel_o !== '0 || sol_o !== 1'b0 || eol_o !== 1'b0 || mem_addr_o !== '0) begin
      fails++;
      $display("FAIL mrst_outputs: valid=%b rd=%b busy=%b done=%b pix=%0d, required all 0",
               valid_o, mem_rd_o, busy_o, frame_done_o, pixel_o);
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      tests++;
      if (frame_done_o !== 1'b0 || valid_o !== 1'b0 || busy_o !== 1'b0) begin
        fails++;
        $display("FAIL mrst_quiet: done=%b valid=%b busy=%b, required 0 0 0", frame_done_o, valid_o, busy_o);
      end
    end
    kick();
    for (int k = 1; k <= 60 && !done; k++) begin
      if (k > 1) @(negedge clk);
      if (valid_o) begin
        if (got == 0) begin
          tests++;
          if (pixel_o !== 8'd1 || sol_o !== 1'b1) begin
            fails++;
            $display("FAIL mrst_restart: first pix=%0d sol=%b, required pix=1 sol=1", pixel_o, sol_o);
          end
        end
        got++;
      end
      if (frame_done_o) done = 1'b1;
    end
    tests++;
    if (!done || got != N) begin
      fails++;
      $display("FAIL mrst_frame: done=%b pixels=%0d, required done=1 pixels=%0d", done, got, N);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_ignored_inputs();
    test_backpressure();
    test_random_frames();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
